// File: rtl/m_axi_read_poller.sv
// AXI4-Lite read poller: repeatedly reads one register until (data & mask) == expect,
// the try budget runs out, the slave errors, or the poll is aborted. Optional macro: M_AXI_READ_POLL_PROFILE_EN.
module m_axi_read_poller #(
  parameter int GLOB_ADDR_WIDTH     = 32,
  parameter int GLOB_DATA_WIDTH     = 32,
  parameter int POLL_GAP            = 16,
  parameter int POLL_GAP_WIDTH      = 8,
  parameter int POLL_TRIES_WIDTH    = 16,
  parameter int POLL_MAX_TRIES      = 1000,
  parameter int BANK1_PROFILE_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           poll_start,
  input  logic                           poll_abort,
  input  logic [GLOB_ADDR_WIDTH-1:0]     poll_addr,
  input  logic [GLOB_DATA_WIDTH-1:0]     poll_mask,
  input  logic [GLOB_DATA_WIDTH-1:0]     poll_expect,
  output logic                           poll_busy,
  output logic                           poll_done,
  output logic                           poll_ok,
  output logic                           poll_timeout_err,
  output logic                           poll_resp_err,
  output logic                           poll_aborted,
  output logic [GLOB_DATA_WIDTH-1:0]     poll_last_data,
  output logic [POLL_TRIES_WIDTH-1:0]    poll_tries,
  output logic [BANK1_PROFILE_WIDTH-1:0] poll_cycle_cnt,
  output logic [GLOB_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // ARVALID/ARADDR never change while waiting for ARREADY, and RREADY is high only in DATA.

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  localparam logic [POLL_GAP_WIDTH-1:0]   GAP_LOAD  = POLL_GAP_WIDTH'(POLL_GAP);
  localparam logic [POLL_TRIES_WIDTH-1:0] TRY_LIMIT = POLL_TRIES_WIDTH'(POLL_MAX_TRIES);

  state_t                      state;
  logic [GLOB_ADDR_WIDTH-1:0]  addr_q;
  logic [GLOB_DATA_WIDTH-1:0]  mask_q;
  logic [GLOB_DATA_WIDTH-1:0]  expect_q;
  logic [POLL_GAP_WIDTH-1:0]   gap_cnt;
  logic [POLL_TRIES_WIDTH-1:0] tries_next;
  logic                        data_match;
  logic                        budget_spent;

  // Only RRESP[1] (SLVERR/DECERR) matters; EXOKAY is treated like OKAY.
  logic unused_rresp_lsb;
  assign unused_rresp_lsb = M_AXI_RRESP[0];

  always_comb begin
    tries_next   = (&poll_tries) ? poll_tries : poll_tries + 1'b1;
    data_match   = ((M_AXI_RDATA & mask_q) == expect_q);
    budget_spent = (POLL_MAX_TRIES != 0) && (tries_next == TRY_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      addr_q           <= '0;
      mask_q           <= '0;
      expect_q         <= '0;
      gap_cnt          <= '0;
      poll_busy        <= 1'b0;
      poll_done        <= 1'b0;
      poll_ok          <= 1'b0;
      poll_timeout_err <= 1'b0;
      poll_resp_err    <= 1'b0;
      poll_aborted     <= 1'b0;
      poll_last_data   <= '0;
      poll_tries       <= '0;
      M_AXI_ARADDR     <= '0;
      M_AXI_ARVALID    <= 1'b0;
      M_AXI_RREADY     <= 1'b0;
    end else begin
      poll_done <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_start) begin
            addr_q           <= poll_addr;
            mask_q           <= poll_mask;
            expect_q         <= poll_expect;
            poll_tries       <= '0;
            poll_ok          <= 1'b0;
            poll_timeout_err <= 1'b0;
            poll_resp_err    <= 1'b0;
            poll_aborted     <= 1'b0;
            poll_busy        <= 1'b1;
            M_AXI_ARVALID    <= 1'b1;
            M_AXI_ARADDR     <= poll_addr;
            state            <= ADDR;
          end
        end
        ADDR: begin
          // Abort is deliberately not looked at here: the AR beat must complete.
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_RREADY  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY   <= 1'b0;
            poll_last_data <= M_AXI_RDATA;
            poll_tries     <= tries_next;
            if (M_AXI_RRESP[1]) begin
              poll_resp_err <= 1'b1;
              poll_done     <= 1'b1;
              poll_busy     <= 1'b0;
              state         <= IDLE;
            end else if (data_match) begin
              poll_ok   <= 1'b1;
              poll_done <= 1'b1;
              poll_busy <= 1'b0;
              state     <= IDLE;
            end else if (budget_spent) begin
              poll_timeout_err <= 1'b1;
              poll_done        <= 1'b1;
              poll_busy        <= 1'b0;
              state            <= IDLE;
            end else if (poll_abort) begin
              poll_aborted <= 1'b1;
              poll_done    <= 1'b1;
              poll_busy    <= 1'b0;
              state        <= IDLE;
            end else if (POLL_GAP == 0) begin
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= addr_q;
              state         <= ADDR;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          // The counter holds the remaining idle cycles including this one.
          if (poll_abort) begin
            poll_aborted <= 1'b1;
            poll_done    <= 1'b1;
            poll_busy    <= 1'b0;
            state        <= IDLE;
          end else if (gap_cnt <= 1) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= addr_q;
            state         <= ADDR;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          poll_busy     <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_ARADDR  <= '0;
          M_AXI_RREADY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef M_AXI_READ_POLL_PROFILE_EN
  // Counts cycles spent busy in the current or most recent poll, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cycle_cnt <= '0;
    end else if (state == IDLE && poll_start) begin
      poll_cycle_cnt <= '0;
    end else if (state != IDLE && !(&poll_cycle_cnt)) begin
      poll_cycle_cnt <= poll_cycle_cnt + 1'b1;
    end
  end
`else
  assign poll_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_m_axi_read_poller.sv
// Bench for m_axi_read_poller: AXI-Lite slave model, directed + random polls,
// expected outcomes computed from the response list and checked by a done monitor.
`timescale 1ns/1ps
module tb_m_axi_read_poller;
  localparam int AW = 32, DW = 32, GAP = 4, GW = 8, TW = 16, MAXT = 5, PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          poll_start, poll_abort;
  logic [AW-1:0] poll_addr;
  logic [DW-1:0] poll_mask, poll_expect;
  logic          poll_busy, poll_done, poll_ok, poll_timeout_err, poll_resp_err, poll_aborted;
  logic [DW-1:0] poll_last_data;
  logic [TW-1:0] poll_tries;
  logic [PW-1:0] poll_cycle_cnt;
  logic [AW-1:0] m_araddr;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid, m_rready;

  always #5 clk = ~clk;

  m_axi_read_poller #(
    .GLOB_ADDR_WIDTH(AW), .GLOB_DATA_WIDTH(DW), .POLL_GAP(GAP), .POLL_GAP_WIDTH(GW),
    .POLL_TRIES_WIDTH(TW), .POLL_MAX_TRIES(MAXT), .BANK1_PROFILE_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .poll_start(poll_start), .poll_abort(poll_abort),
    .poll_addr(poll_addr), .poll_mask(poll_mask), .poll_expect(poll_expect),
    .poll_busy(poll_busy), .poll_done(poll_done), .poll_ok(poll_ok),
    .poll_timeout_err(poll_timeout_err), .poll_resp_err(poll_resp_err),
    .poll_aborted(poll_aborted), .poll_last_data(poll_last_data), .poll_tries(poll_tries),
    .poll_cycle_cnt(poll_cycle_cnt), .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
    .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
  );

  typedef struct packed {
    logic          ok;
    logic          tmo;
    logic          rerr;
    logic          abrt;
    logic [TW-1:0] tries;
    logic [DW-1:0] last;
    int            reads;
    int            ar_base;
    int            busy;       // expected busy cycles, or -1 to derive from start/done times
    int            start_cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [33:0]   stim_q[$];    // {rresp, rdata} per read, in order
  logic [33:0]   resp_q[$];
  int            checks = 0, failures = 0;
  int            cyc = 0;
  int            ar_count = 0, r_count = 0;
  int            stall_left = 0, stall_max = 0, lat_max = 0, lat = 0, sstate = 0;
  int            r_hs_cyc = 0;
  bit            gap_pending = 0, ar_wait = 0, hold_r = 0;
  logic [AW-1:0] cur_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // AXI-Lite slave: inputs driven and outputs sampled on the falling edge.
  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_arready = 0; m_rvalid = 0; sstate = 0; gap_pending = 0; ar_wait = 0;
        continue;
      end
      if (ar_wait) check("arvalid_held", m_arvalid, 1'b1);
      if (m_arready) begin
        m_arready = 0; ar_count++; sstate = 1;
        lat = $urandom_range(0, lat_max);
        stall_left = $urandom_range(0, stall_max);
      end
      if (m_rvalid) begin
        m_rvalid = 0; r_count++; r_hs_cyc = cyc; gap_pending = 1;
      end
      if (poll_done) gap_pending = 0;
      if (!m_arvalid) begin
        check("araddr_zero_when_idle", m_araddr, '0);
      end else begin
        check("araddr", m_araddr, cur_addr);
        if (gap_pending) begin
          check("gap_idle_cycles_ge", (cyc - r_hs_cyc) >= GAP, 1'b1);
          gap_pending = 0;
        end
        if (sstate == 0) begin
          if (stall_left > 0) stall_left--;
          else m_arready = 1;
        end
      end
      ar_wait = m_arvalid && !m_arready;
      if (sstate == 1 && m_rready && !hold_r) begin
        if (lat > 0) lat--;
        else begin
          if (resp_q.size() == 0) begin
            check("resp_available", 1'b0, 1'b1);
            m_rdata = '0; m_rresp = 2'b00;
          end else begin
            {m_rresp, m_rdata} = resp_q.pop_front();
          end
          m_rvalid = 1; sstate = 0;
        end
      end
    end
  end

  // Done monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (poll_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("done_ok", poll_ok, e.ok);
          check("done_timeout_err", poll_timeout_err, e.tmo);
          check("done_resp_err", poll_resp_err, e.rerr);
          check("done_aborted", poll_aborted, e.abrt);
          check("done_tries", poll_tries, e.tries);
          check("done_last_data", poll_last_data, e.last);
          check("done_ar_count", ar_count - e.ar_base, e.reads);
          check("done_busy_low", poll_busy, 1'b0);
`ifdef M_AXI_READ_POLL_PROFILE_EN
          if (e.busy >= 0) check("cycle_cnt", poll_cycle_cnt, e.busy);
          else check("cycle_cnt", poll_cycle_cnt, cyc - e.start_cyc - 1);
`else
          check("cycle_cnt_tied", poll_cycle_cnt, '0);
`endif
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    exp_q.delete();
  endtask

  // Issues one poll using stim_q as the slave's responses; returns at the done cycle.
  task automatic run_poll(input logic [AW-1:0] addr, input logic [DW-1:0] mask,
                          input logic [DW-1:0] expv, input int abort_k,
                          input int first_stall, input bit extra_start, input int exp_busy);
    exp_t e;
    int   t, budget, r_base;
    bit   fin;
    e = '0; t = 0; fin = 0;
    foreach (stim_q[i]) begin
      if (!fin) begin
        t++;
        e.last = stim_q[i][31:0];
        if (stim_q[i][33]) begin e.rerr = 1; fin = 1; end
        else if ((stim_q[i][31:0] & mask) == expv) begin e.ok = 1; fin = 1; end
        else if (t == MAXT) begin e.tmo = 1; fin = 1; end
        else if (t == abort_k) begin e.abrt = 1; fin = 1; end
      end
    end
    e.tries = TW'(t); e.reads = t; e.busy = exp_busy;
    e.ar_base = ar_count; e.start_cyc = cyc;
    resp_q = stim_q;
    cur_addr = addr;
    stall_left = first_stall;
    exp_q.push_back(e);
    poll_addr = addr; poll_mask = mask; poll_expect = expv; poll_start = 1;
    @(negedge clk);
    poll_start = 0;
    r_base = r_count;
    budget = 0;
    while (!poll_done && budget < 3000) begin
      if (abort_k > 0 && (r_count - r_base) >= abort_k) poll_abort = 1;
      if (extra_start && budget == 3) begin
        poll_start = 1; poll_addr = 32'h34; poll_mask = '1; poll_expect = '0;
      end else begin
        poll_start = 0;
      end
      @(negedge clk);
      budget++;
    end
    poll_abort = 0;
    poll_start = 0;
    if (!poll_done) begin
      check("poll_done_within_budget", 1'b0, 1'b1);
      do_reset();
    end
  endtask

  initial begin
    logic [DW-1:0] mask, expv, d;
    int            k, abort_k, dones;
    logic [1:0]    rr;
    reset = 1; poll_start = 0; poll_abort = 0;
    poll_addr = '0; poll_mask = '0; poll_expect = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", poll_busy, 1'b0);
    check("rst_done", poll_done, 1'b0);
    check("rst_ok", poll_ok, 1'b0);
    check("rst_timeout_err", poll_timeout_err, 1'b0);
    check("rst_resp_err", poll_resp_err, 1'b0);
    check("rst_aborted", poll_aborted, 1'b0);
    check("rst_last_data", poll_last_data, '0);
    check("rst_tries", poll_tries, '0);
    check("rst_cycle_cnt", poll_cycle_cnt, '0);
    check("rst_arvalid", m_arvalid, 1'b0);
    check("rst_araddr", m_araddr, '0);
    check("rst_rready", m_rready, 1'b0);
    reset = 0;
    @(negedge clk);

    // First-read match: ADDR one cycle, DATA one cycle.
    stall_max = 0; lat_max = 0;
    stim_q = '{{2'b00, 32'h0000_0002}};
    run_poll(32'h04, 32'h2, 32'h2, 0, 0, 0, 2);
    // Gap spacing, three reads.
    stim_q = '{{2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h2}};
    run_poll(32'h04, 32'h2, 32'h2, 0, 0, 0, -1);
    // Timeout after exactly five reads; the sixth entry must never be fetched.
    stim_q = '{{2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0},
               {2'b00, 32'h0}, {2'b00, 32'h2}};
    run_poll(32'h08, 32'h2, 32'h2, 0, 0, 0, -1);
    // Slave error wins over a matching value.
    stim_q = '{{2'b10, 32'h2}, {2'b00, 32'h2}};
    run_poll(32'h0C, 32'h2, 32'h2, 0, 0, 0, -1);
    // AR backpressure with an ignored start, then abort during the gap after read 2.
    stim_q = '{{2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}};
    run_poll(32'h04, 32'h2, 32'h2, 2, 10, 1, -1);

    // Randomized polls with random AR stalls and R latency.
    stall_max = 3; lat_max = 3;
    for (int p = 0; p < 40; p++) begin
      mask = $urandom;
      if (mask == '0) mask = 32'h1;
      expv = $urandom & mask;
      stim_q.delete();
      for (int r = 0; r < 6; r++) begin
        k = $urandom_range(0, 9);
        d = $urandom;
        if (k < 2) d = expv | (d & ~mask);
        rr = (k == 9) ? 2'b10 : ((k == 8) ? 2'b11 : {1'b0, d[0]});
        stim_q.push_back({rr, d});
      end
      abort_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_poll($urandom, mask, expv, abort_k, $urandom_range(0, 3), 0, -1);
    end

    // Reset while waiting in DATA: no done pulse, handshake outputs dropped.
    stall_max = 0; lat_max = 0; hold_r = 1;
    resp_q = '{{2'b00, 32'h2}};
    cur_addr = 32'h10;
    k = ar_count;
    poll_addr = 32'h10; poll_mask = 32'h2; poll_expect = 32'h2; poll_start = 1;
    @(negedge clk);
    poll_start = 0;
    for (int i = 0; i < 50 && ar_count == k; i++) @(negedge clk);
    check("reset_test_ar_issued", ar_count - k, 1);
    @(negedge clk);
    check("rready_in_data", m_rready, 1'b1);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    check("post_rst_busy", poll_busy, 1'b0);
    check("post_rst_arvalid", m_arvalid, 1'b0);
    check("post_rst_rready", m_rready, 1'b0);
    check("post_rst_tries", poll_tries, '0);
    check("post_rst_last_data", poll_last_data, '0);
    hold_r = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (poll_done) dones++;
      @(negedge clk);
    end
    check("post_rst_no_done", dones, 0);

    // Recovery after reset.
    stim_q = '{{2'b00, 32'h0000_0002}};
    run_poll(32'h04, 32'h2, 32'h2, 0, 0, 0, 2);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/m_axi_read_poller.md
Name: m_axi_read_poller

Overview:
- Sequencer-side controller that owns the AXI4-Lite master read channel to the DMA control registers.
- On command, it repeatedly reads one DMA register until a masked compare matches, the try budget runs out, or the slave returns an error.
- Used by the DFX sequencer to wait for DMA idle/done before advancing to the next bank-1 slot.
- Exactly one read is outstanding at any time.

Parameters:
GLOB_ADDR_WIDTH, 32, AXI address width
GLOB_DATA_WIDTH, 32, AXI data width
POLL_GAP, 16, idle cycles between a non-matching read response and the next ARVALID; 0 = back-to-back
POLL_GAP_WIDTH, 8, gap counter width; POLL_GAP must be < 2^POLL_GAP_WIDTH
POLL_TRIES_WIDTH, 16, try counter width
POLL_MAX_TRIES, 1000, read budget; 0 = unlimited
BANK1_PROFILE_WIDTH, 32, profile counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
poll_start  in  1  one-cycle command strobe; honoured only when idle
poll_abort  in  1  level; stop polling at the next safe point
poll_addr  in  GLOB_ADDR_WIDTH  register address to poll
poll_mask  in  GLOB_DATA_WIDTH  compare mask
poll_expect  in  GLOB_DATA_WIDTH  expected value of (RDATA & mask)
poll_busy  out  1  high while not IDLE
poll_done  out  1  one-cycle completion pulse
poll_ok  out  1  compare matched; valid with poll_done, held until next start
poll_timeout_err  out  1  try budget exhausted; held until next start
poll_resp_err  out  1  RRESP[1] set; held until next start
poll_aborted  out  1  ended by poll_abort; held until next start
poll_last_data  out  GLOB_DATA_WIDTH  last RDATA captured
poll_tries  out  POLL_TRIES_WIDTH  reads completed in current or last poll
poll_cycle_cnt  out  BANK1_PROFILE_WIDTH  see Optional Feature
M_AXI_ARADDR  out  GLOB_ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  GLOB_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, ADDR, DATA, GAP.
- IDLE:
  - On poll_start, latch addr/mask/expect.
  - Clear tries, poll_ok and all error/abort flags.
  - Go to ADDR next cycle. First ARVALID appears one cycle after the start strobe.
- ADDR:
  - ARVALID=1 with ARADDR = latched address; both stay stable until ARREADY.
  - On ARVALID&&ARREADY, go to DATA.
  - poll_abort is not honoured here; the handshake must complete.
- DATA:
  - RREADY=1 only in this state.
  - On RVALID: capture RDATA into poll_last_data and increment tries (saturating). Then resolve in this priority order:
    1. RRESP[1]=1 → resp_err, finish.
    2. (RDATA & mask) == expect → ok, finish.
    3. POLL_MAX_TRIES != 0 and new tries == POLL_MAX_TRIES → timeout_err, finish.
    4. poll_abort high → aborted, finish.
    5. Otherwise go to GAP, or straight to ADDR if POLL_GAP == 0.
- GAP:
  - Load the counter with POLL_GAP on entry and decrement each cycle; go to ADDR when it reaches 1.
  - poll_abort in GAP → aborted, finish next cycle without issuing a read.
- Finish:
  - State returns to IDLE and poll_done pulses high for exactly one cycle. This is the cycle after the RVALID handshake, or the cycle after abort is sampled in GAP.
  - poll_start in the poll_done cycle is accepted (state is already IDLE).
- poll_start while busy is ignored; latched values do not change.
- ARADDR is 0 whenever ARVALID is low.
- Reset mid-transaction: next cycle the block is IDLE with ARVALID/RREADY low and no done pulse. The DMA interconnect shares this reset, so the abandoned transaction is not tracked.

Optional Feature:
- Macro: M_AXI_READ_POLL_PROFILE_EN.
- Defined: poll_cycle_cnt clears on an accepted poll_start and increments every busy cycle, saturating at all-ones. It holds its value after poll_done until the next start.
- Undefined: the counter logic is absent and poll_cycle_cnt is tied to 0.

Test Plan:
- First-read match: start addr=0x04, mask=0x2, expect=0x2; ARREADY high; RVALID one cycle after AR with RDATA=0x00000002 → exactly one AR handshake, poll_done one cycle after R handshake, ok=1, tries=1, last_data=0x2.
- Gap spacing: POLL_GAP=4; responses 0x0, 0x0, 0x2 → 3 AR handshakes, ≥4 idle cycles between each R handshake and the next ARVALID, ok=1, tries=3.
- Timeout: POLL_MAX_TRIES=5, RDATA always 0 → exactly 5 reads, timeout_err=1, ok=0, tries=5; no sixth ARVALID.
- Slave error: first response RRESP=2'b10, RDATA=0x2 → resp_err=1, ok=0 (error wins over match), done, no further AR.
- Backpressure and ignored start: ARREADY held low 10 cycles, extra poll_start with addr=0x34 mid-wait → ARVALID held high, ARADDR stays 0x04; abort raised during GAP → aborted=1, done, no new ARVALID.
- Reset in DATA state → next cycle busy=0, ARVALID=0, RREADY=0, poll_done never pulses. With M_AXI_READ_POLL_PROFILE_EN, poll_cycle_cnt equals the busy-cycle count of the first-read-match test.
